// File: rtl/mouse_tracker_pkg.sv
// Shared definitions for the PS/2 mouse tracker: FSM states, header bit positions,
// screen extents shared with the graphics stage, and header/delta helpers.
package mouse_tracker_pkg;

    typedef enum logic [1:0] {
        StWaitB1,
        StWaitB2,
        StWaitB3,
        StUpdate
    } state_e;

    localparam int unsigned BtnL    = 0;
    localparam int unsigned BtnR    = 1;
    localparam int unsigned BtnM    = 2;
    localparam int unsigned HdrSync = 3;
    localparam int unsigned XSign   = 4;
    localparam int unsigned YSign   = 5;
    localparam int unsigned XOvf    = 6;
    localparam int unsigned YOvf    = 7;

    localparam int unsigned HMaxDefault = 640;
    localparam int unsigned VMaxDefault = 480;

    // Header minus the always-one sync bit.
    typedef struct packed {
        logic       y_ovf;
        logic       x_ovf;
        logic       y_sign;
        logic       x_sign;
        logic [2:0] btn;
    } header_t;

    function automatic header_t decode_header(input logic [7:0] b);
        header_t h;
        h.y_ovf  = b[YOvf];
        h.x_ovf  = b[XOvf];
        h.y_sign = b[YSign];
        h.x_sign = b[XSign];
        h.btn    = {b[BtnM], b[BtnR], b[BtnL]};
        return h;
    endfunction

    // 9-bit two's complement delta; an overflowed axis contributes no motion.
    function automatic logic [8:0] axis_delta(input logic sign, input logic ovf,
                                              input logic [7:0] mag);
        return ovf ? 9'd0 : {sign, mag};
    endfunction

endpackage

// File: rtl/mouse_axis_clamp.sv
// Combinational position update for one axis: pos +/- delta, saturated to 0..MAX-1.
module mouse_axis_clamp #(
    parameter int unsigned MAX = 640
) (
    input  logic [9:0] pos,
    input  logic [8:0] delta,
    input  logic       sub,
    output logic [9:0] pos_clamped
);

    localparam logic signed [11:0] Limit = 12'(MAX - 1);

    logic signed [11:0] p;
    logic signed [11:0] d;
    logic signed [11:0] r;

    always_comb begin
        p = signed'({2'b00, pos});
        d = signed'({{3{delta[8]}}, delta});
        r = sub ? (p - d) : (p + d);
        if (r < 12'sd0) begin
            pos_clamped = '0;
        end else if (r > Limit) begin
            pos_clamped = Limit[9:0];
        end else begin
            pos_clamped = r[9:0];
        end
    end

endmodule

// File: rtl/mouse_tracker.sv
// Assembles 3-byte PS/2 mouse packets and integrates them into a clamped absolute
// cursor position plus button state, with resync on framing errors and timeouts.
module mouse_tracker
    import mouse_tracker_pkg::*;
#(
    parameter int unsigned H_MAX   = HMaxDefault,
    parameter int unsigned V_MAX   = VMaxDefault,
    parameter int unsigned X_INIT  = 320,
    parameter int unsigned Y_INIT  = 240,
    parameter int unsigned TIMEOUT = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done_tick,
    output logic [9:0] mouse_x,
    output logic [9:0] mouse_y,
    output logic [2:0] btn,
    output logic       pkt_done_tick
);

    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] IdleLast = CntW'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] idle_q, idle_d;
    header_t         hdr_q, hdr_d;
    logic [7:0]      xb_q, xb_d;
    logic [7:0]      yb_q, yb_d;
    logic [9:0]      x_q, x_d;
    logic [9:0]      y_q, y_d;
    logic [2:0]      btn_q, btn_d;
    logic            tick_q, tick_d;
    logic [9:0]      x_new, y_new;

    mouse_axis_clamp #(
        .MAX (H_MAX)
    ) u_clamp_x (
        .pos         (x_q),
        .delta       (axis_delta(hdr_q.x_sign, hdr_q.x_ovf, xb_q)),
        .sub         (1'b0),
        .pos_clamped (x_new)
    );

    // PS/2 y grows upward, screen y grows downward.
    mouse_axis_clamp #(
        .MAX (V_MAX)
    ) u_clamp_y (
        .pos         (y_q),
        .delta       (axis_delta(hdr_q.y_sign, hdr_q.y_ovf, yb_q)),
        .sub         (1'b1),
        .pos_clamped (y_new)
    );

    always_comb begin
        state_d = state_q;
        idle_d  = '0;
        hdr_d   = hdr_q;
        xb_d    = xb_q;
        yb_d    = yb_q;
        x_d     = x_q;
        y_d     = y_q;
        btn_d   = btn_q;
        tick_d  = 1'b0;
        unique case (state_q)
            StWaitB1: begin
                if (rx_done_tick && rx_data[HdrSync]) begin
                    hdr_d   = decode_header(rx_data);
                    state_d = StWaitB2;
                end
            end
            StWaitB2: begin
                if (rx_done_tick) begin
                    xb_d    = rx_data;
                    state_d = StWaitB3;
                end else if (idle_q == IdleLast) begin
                    state_d = StWaitB1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            StWaitB3: begin
                if (rx_done_tick) begin
                    yb_d    = rx_data;
                    state_d = StUpdate;
                end else if (idle_q == IdleLast) begin
                    state_d = StWaitB1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            StUpdate: begin
                x_d     = x_new;
                y_d     = y_new;
                btn_d   = hdr_q.btn;
                tick_d  = 1'b1;
                state_d = StWaitB1;
            end
            default: state_d = StWaitB1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StWaitB1;
            idle_q  <= '0;
            hdr_q   <= '0;
            xb_q    <= '0;
            yb_q    <= '0;
            x_q     <= 10'(X_INIT);
            y_q     <= 10'(Y_INIT);
            btn_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            hdr_q   <= hdr_d;
            xb_q    <= xb_d;
            yb_q    <= yb_d;
            x_q     <= x_d;
            y_q     <= y_d;
            btn_q   <= btn_d;
            tick_q  <= tick_d;
        end
    end

    assign mouse_x       = x_q;
    assign mouse_y       = y_q;
    assign btn           = btn_q;
    assign pkt_done_tick = tick_q;

endmodule

// File: tb/tb_mouse_tracker.sv
// Scoreboard bench for mouse_tracker: a packet-level model predicts every update,
// a monitor checks each pkt_done_tick and output stability between strobes.
module tb_mouse_tracker;

    localparam int TO = 200;
    localparam int XI = 320;
    localparam int YI = 240;
    localparam int HM = 640;
    localparam int VM = 480;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done_tick;
    logic [9:0] mouse_x;
    logic [9:0] mouse_y;
    logic [2:0] btn;
    logic       pkt_done_tick;

    mouse_tracker #(
        .H_MAX   (HM),
        .V_MAX   (VM),
        .X_INIT  (XI),
        .Y_INIT  (YI),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_done_tick  (rx_done_tick),
        .mouse_x       (mouse_x),
        .mouse_y       (mouse_y),
        .btn           (btn),
        .pkt_done_tick (pkt_done_tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int x;
        int y;
        int b;
        int at;
    } exp_t;

    exp_t exp_q[$];

    // Model state: position after every predicted packet, bytes of the open packet.
    int         mx, my, mb;
    logic [7:0] part[$];
    int         last_cyc;
    int         done_cyc;
    int         shown_x, shown_y, shown_b;

    function automatic int clamp(input int v, input int max);
        if (v < 0) return 0;
        if (v > max - 1) return max - 1;
        return v;
    endfunction

    task automatic model_tick(input logic [7:0] b);
        logic [7:0] h;
        int dx, dy;
        exp_t e;
        if (part.size() > 0 && (cyc - last_cyc) > TO) part.delete();
        if (cyc - done_cyc == 1) return;          // arrives while the update is applied
        if (part.size() == 0 && !b[3]) return;    // not a header candidate
        part.push_back(b);
        last_cyc = cyc;
        if (part.size() == 3) begin
            h  = part[0];
            dx = h[4] ? int'(part[1]) - 256 : int'(part[1]);
            dy = h[5] ? int'(part[2]) - 256 : int'(part[2]);
            if (h[6]) dx = 0;
            if (h[7]) dy = 0;
            mx = clamp(mx + dx, HM);
            my = clamp(my - dy, VM);
            mb = {29'd0, h[2], h[1], h[0]};
            e.x = mx; e.y = my; e.b = mb; e.at = cyc + 2;
            exp_q.push_back(e);
            done_cyc = cyc;
            part.delete();
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data      = b;
        rx_done_tick = 1'b1;
        model_tick(b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_done_tick = 1'b0;
        end
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send(a);
        send(b);
        send(c);
        idle(4);
    endtask

    task automatic model_reset();
        exp_q.delete();
        part.delete();
        mx = XI; my = YI; mb = 0;
        shown_x = XI; shown_y = YI; shown_b = 0;
        done_cyc = -100;
        last_cyc = -100;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        model_reset();
        reset = 1'b1;
        #1;
        check("async_rst_x", int'(mouse_x), XI);
        check("async_rst_y", int'(mouse_y), YI);
        check("async_rst_btn", int'(btn), 0);
        check("async_rst_tick", int'(pkt_done_tick), 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: every strobe must match the next prediction on time; between strobes
    // the outputs must hold the last applied values.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (pkt_done_tick) begin
                if (exp_q.size() == 0) begin
                    check("spurious_pkt_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pkt_x", int'(mouse_x), e.x);
                    check("pkt_y", int'(mouse_y), e.y);
                    check("pkt_btn", int'(btn), e.b);
                    check("pkt_latency", cyc, e.at);
                    shown_x = e.x; shown_y = e.y; shown_b = e.b;
                end
            end else begin
                check("hold_x", int'(mouse_x), shown_x);
                check("hold_y", int'(mouse_y), shown_y);
                check("hold_btn", int'(btn), shown_b);
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int r;
        model_reset();
        reset        = 1'b1;
        rx_data      = 8'h00;
        rx_done_tick = 1'b0;
        #1;
        check("por_x", int'(mouse_x), XI);
        check("por_y", int'(mouse_y), YI);
        check("por_btn", int'(btn), 0);
        check("por_tick", int'(pkt_done_tick), 0);
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        // Basic move.
        send3(8'h08, 8'h0A, 8'h05);
        check("basic_x", int'(mouse_x), 330);
        check("basic_y", int'(mouse_y), 235);
        check("basic_btn", int'(btn), 0);

        // Reset in the middle of a packet, then a fresh packet.
        send(8'h08);
        send(8'h10);
        idle(1);
        do_reset();
        send3(8'h08, 8'h03, 8'h03);
        check("post_rst_x", int'(mouse_x), 323);
        check("post_rst_y", int'(mouse_y), 237);

        // Large negative x with low clamp.
        do_reset();
        send3(8'h19, 8'h00, 8'h00);
        check("neg_x1", int'(mouse_x), 64);
        check("neg_y1", int'(mouse_y), 240);
        check("neg_btn", int'(btn), 1);
        send3(8'h19, 8'h00, 8'h00);
        check("neg_x2", int'(mouse_x), 0);
        send3(8'h19, 8'h00, 8'h00);
        check("neg_x3", int'(mouse_x), 0);

        // X overflow ignored, y high clamp.
        do_reset();
        send3(8'h68, 8'h7F, 8'h80);
        check("ovf_x", int'(mouse_x), 320);
        check("ovf_y1", int'(mouse_y), 368);
        send3(8'h68, 8'h7F, 8'h80);
        check("ovf_y2", int'(mouse_y), 479);
        send3(8'h68, 8'h7F, 8'h80);
        check("ovf_y3", int'(mouse_y), 479);

        // Resync on framing errors.
        send(8'h00);
        send(8'h05);
        send3(8'h08, 8'h01, 8'h01);
        check("resync_x", int'(mouse_x), 321);
        check("resync_y", int'(mouse_y), 478);

        // Timeout discards a stale partial packet.
        send(8'h08);
        send(8'h10);
        idle(TO + 2);
        send3(8'h08, 8'h02, 8'h02);
        check("timeout_x", int'(mouse_x), 323);
        check("timeout_y", int'(mouse_y), 476);

        // Randomised stream with gaps around the timeout boundary.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50) begin
            end else if (r < 85) begin
                idle($urandom_range(1, 5));
            end else if (r < 95) begin
                idle($urandom_range(TO - 2, TO + 2));
            end else begin
                idle(TO + 5);
            end
            b = 8'($urandom);
            if ($urandom_range(0, 9) < 8) b[3] = 1'b1;
            send(b);
        end
        idle(10);
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
